// File: rtl/ram_dp_p1_ctrl.sv
// Burst read / single write controller for an asynchronous single-port RAM with a shared data bus.
// Optional build macro RAM_DP_P1_CTRL_STATS_EN adds saturating wr_count / rd_count strobe counters.
module ram_dp_p1_ctrl #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 6,
  parameter int unsigned RAM_DEPTH   = 64,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH-1:0] cmd_len,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  wr_done,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
`ifdef RAM_DP_P1_CTRL_STATS_EN
  output logic [15:0]           wr_count,
  output logic [15:0]           rd_count,
`endif
  inout  wire  [DATA_WIDTH-1:0] ram_data
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0]      WAIT_RELOAD = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(RAM_DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    RD_ACCESS,
    TURN
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        wait_cnt;
  logic [ADDR_WIDTH-1:0]   beats_left;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    drive_q;

  // The bus is only driven from WR_SETUP through WR_HOLD; ram_oe is never high then.
  assign ram_data = drive_q ? wdata_q : {DATA_WIDTH{1'bz}};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cmd_ready   <= 1'b0;
      wait_cnt    <= '0;
      beats_left  <= '0;
      wdata_q     <= '0;
      drive_q     <= 1'b0;
      ram_address <= '0;
      ram_cs      <= 1'b0;
      ram_we      <= 1'b0;
      ram_oe      <= 1'b0;
      rd_valid    <= 1'b0;
      rd_last     <= 1'b0;
      rd_data     <= '0;
      wr_done     <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      wr_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready   <= 1'b0;
            ram_address <= cmd_addr;
            ram_cs      <= 1'b1;
            if (cmd_we) begin
              wdata_q <= cmd_wdata;
              drive_q <= 1'b1;
              state   <= WR_SETUP;
            end else begin
              ram_oe     <= 1'b1;
              beats_left <= cmd_len;
              wait_cnt   <= WAIT_RELOAD;
              state      <= RD_ACCESS;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        WR_SETUP: begin
          ram_we   <= 1'b1;
          wait_cnt <= WAIT_RELOAD;
          state    <= WR_PULSE;
        end
        WR_PULSE: begin
          if (wait_cnt == '0) begin
            ram_we <= 1'b0;
            state  <= WR_HOLD;
          end else begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end
        end
        WR_HOLD: begin
          ram_cs    <= 1'b0;
          drive_q   <= 1'b0;
          wr_done   <= 1'b1;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        RD_ACCESS: begin
          if (wait_cnt == '0) begin
            rd_data  <= ram_data;
            rd_valid <= 1'b1;
            if (beats_left == '0) begin
              rd_last <= 1'b1;
              ram_cs  <= 1'b0;
              ram_oe  <= 1'b0;
              state   <= TURN;
            end else begin
              beats_left  <= beats_left - ADDR_WIDTH'(1);
              wait_cnt    <= WAIT_RELOAD;
              ram_address <= (ram_address == LAST_ADDR) ? '0 : ram_address + ADDR_WIDTH'(1);
            end
          end else begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end
        end
        TURN: begin
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          cmd_ready <= 1'b0;
          drive_q   <= 1'b0;
          ram_cs    <= 1'b0;
          ram_we    <= 1'b0;
          ram_oe    <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

`ifdef RAM_DP_P1_CTRL_STATS_EN
  // Strobe counters hold at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_count <= '0;
      rd_count <= '0;
    end else begin
      if (wr_done && (wr_count != 16'hFFFF)) wr_count <= wr_count + 16'd1;
      if (rd_valid && (rd_count != 16'hFFFF)) rd_count <= rd_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ram_dp_p1_ctrl.sv
// Randomized directed bench for ram_dp_p1_ctrl against an asynchronous RAM model and a word-array reference.
module tb_ram_dp_p1_ctrl;
  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 6;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned WAIT  = 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_addr, cmd_len;
  logic [DW-1:0] cmd_wdata;
  logic          rd_valid, rd_last, wr_done;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] ram_address;
  logic          ram_cs, ram_we, ram_oe;
  wire  [DW-1:0] ram_data;
`ifdef RAM_DP_P1_CTRL_STATS_EN
  logic [15:0]   wr_count, rd_count;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int exp_wr   = 0;
  int exp_rd   = 0;

  logic [DW-1:0] mem     [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];

  always #5 clk = ~clk;

  ram_dp_p1_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH), .WAIT_CYCLES(WAIT)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_wdata(cmd_wdata),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .wr_done(wr_done),
    .ram_address(ram_address), .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe),
`ifdef RAM_DP_P1_CTRL_STATS_EN
    .wr_count(wr_count), .rd_count(rd_count),
`endif
    .ram_data(ram_data)
  );

  // Asynchronous-read RAM; a write lands on any clock edge seen while cs and we are high.
  assign ram_data = (ram_cs && ram_oe && !ram_we) ? mem[ram_address] : 'z;
  always @(posedge clk) if (ram_cs && ram_we) mem[ram_address] <= ram_data;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [AW-1:0] a, input logic [AW-1:0] len,
                       input logic [DW-1:0] d);
    logic acc;
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_len = len; cmd_wdata = d;
    acc = 1'b0;
    for (int i = 0; i < 40 && !acc; i++) begin
      acc = cmd_ready;
      tick();
    end
    chk("accept", acc, 1'b1);
    cmd_valid = 1'b0;
    cmd_we    = 1'($urandom);
    cmd_addr  = AW'($urandom);
    cmd_len   = AW'($urandom);
    cmd_wdata = $urandom;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int we_cnt, done_j, j;
    issue(1'b1, a, '0, d);
    ref_mem[a] = d;
    we_cnt = 0; done_j = -1; j = 0;
    while (j < int'(WAIT) + 6 && done_j < 0) begin
      if (j <= int'(WAIT) + 1) chk("wr_bus", ram_data, d);
      chk("wr_no_oe", ram_oe, 1'b0);
      if (ram_we) we_cnt++;
      if (wr_done) done_j = j;
      else begin tick(); j++; end
    end
    chk("wr_pulse_len", we_cnt, WAIT);
    chk("wr_done_lat", done_j, WAIT + 2);
    chk("wr_idle_z", ram_data, 'z);
    exp_wr++;
    tick();
    chk("wr_done_once", wr_done, 1'b0);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [AW-1:0] len, input bit queue_wr,
                         input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    int beat, j, idx;
    issue(1'b0, a, len, '0);
    if (queue_wr) begin
      cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = wa; cmd_wdata = wd;
    end
    beat = 0; j = 0;
    while (beat <= int'(len) && j < (int'(len) + 1) * int'(WAIT) + 8) begin
      if (ram_oe) begin
        idx = (int'(a) + beat) % DEPTH;
        chk("rd_addr", ram_address, idx);
        chk("rd_no_we", ram_we, 1'b0);
        chk("rd_bus", ram_data, ref_mem[idx]);
      end
      tick(); j++;
      if (rd_valid) begin
        chk("rd_beat_time", j, (beat + 1) * int'(WAIT));
        chk("rd_data", rd_data, ref_mem[(int'(a) + beat) % DEPTH]);
        chk("rd_last", rd_last, beat == int'(len));
        beat++;
        exp_rd++;
      end
    end
    chk("rd_beats", beat, int'(len) + 1);
    chk("turn_cs", ram_cs, 1'b0);
    chk("turn_oe", ram_oe, 1'b0);
    chk("turn_z", ram_data, 'z);
    chk("turn_ready", cmd_ready, 1'b0);
    tick();
    chk("post_valid", rd_valid, 1'b0);
    chk("post_ready", cmd_ready, 1'b1);
    chk("post_no_we", ram_we, 1'b0);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_cs"}, ram_cs, 1'b0);
    chk({tag, "_we"}, ram_we, 1'b0);
    chk({tag, "_oe"}, ram_oe, 1'b0);
    chk({tag, "_addr"}, ram_address, '0);
    chk({tag, "_rdv"}, rd_valid, 1'b0);
    chk({tag, "_rdl"}, rd_last, 1'b0);
    chk({tag, "_rdd"}, rd_data, '0);
    chk({tag, "_wrd"}, wr_done, 1'b0);
    chk({tag, "_bus"}, ram_data, 'z);
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b1;
    #1 check_reset_state("rst");
    @(negedge clk) reset = 1'b0;
    exp_wr = 0; exp_rd = 0;
    tick();
    chk("rst_ready", cmd_ready, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] v;
    int seen;
    for (int i = 0; i < int'(DEPTH); i++) begin
      v = $urandom;
      mem[i] = v;
      ref_mem[i] = v;
    end
    reset = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_wdata = '0;
    #12 check_reset_state("init");
    @(negedge clk) reset = 1'b0;
    tick();
    chk("init_ready", cmd_ready, 1'b1);

    do_write(6'd5, 32'hDEADBEEF);
    chk("mem5", mem[5], 32'hDEADBEEF);

    for (int i = 0; i < 4; i++) do_write(AW'(i), DW'(10 + i));
    do_read(6'd0, 6'd3, 1'b0, '0, '0);

    do_read(6'd62, 6'd3, 1'b0, '0, '0);

    do_read(6'd20, 6'd2, 1'b1, 6'd9, 32'hCAFE0009);
    do_write(6'd9, 32'hCAFE0009);
    chk("mem9", mem[9], 32'hCAFE0009);

    issue(1'b0, 6'd30, 6'd3, '0);
    seen = 0;
    for (int k = 0; k < 20 && seen < 2; k++) begin
      tick();
      if (rd_valid) seen++;
    end
    chk("abort_beats", seen, 2);
    #2 reset = 1'b1;
    #1 check_reset_state("abort");
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("abort_quiet", rd_valid, 1'b0);
    end
    @(negedge clk) reset = 1'b0;
    exp_wr = 0; exp_rd = 0;
    tick();
    chk("abort_ready", cmd_ready, 1'b1);
    do_read(6'd7, 6'd0, 1'b0, '0, '0);

    pulse_reset();
    do_write(6'd40, $urandom);
    do_write(6'd41, $urandom);
    do_read(6'd40, 6'd3, 1'b0, '0, '0);
`ifdef RAM_DP_P1_CTRL_STATS_EN
    chk("stats_wr", wr_count, 2);
    chk("stats_rd", rd_count, 4);
`endif

    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 1) == 1) do_write(AW'($urandom), $urandom);
      else do_read(AW'($urandom), AW'($urandom_range(0, 7)), 1'b0, '0, '0);
    end
    for (int i = 0; i < int'(DEPTH); i++) chk("mem_final", mem[i], ref_mem[i]);
`ifdef RAM_DP_P1_CTRL_STATS_EN
    chk("stats_wr_end", wr_count, exp_wr);
    chk("stats_rd_end", rd_count, exp_rd);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
